avalon_mem_arbiter: RTL and testbench
=====================================

Name: avalon_mem_arbiter

Overview:
- Shares one Avalon-MM memory slave (the word-addressed, waitrequest-stalled RAM model used by the CPU testbenches) between the CPU instruction-fetch port and the CPU data port.
- Fixed data-over-instruction priority, with a starvation guard that forces an instruction grant.
- Runs one transaction at a time.
- Registers all master outputs, captures read data, acknowledges the granted requester with a one-cycle pulse, and aborts transactions stalled beyond a timeout.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while instr_req is pending before instr is forced.
- TIMEOUT_CYCLES, 255: waitrequest-high cycles tolerated in ISSUE before abort (1..255).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instr_req  in  1  fetch request; held with instr_addr until instr_ack
- instr_addr  in  32  fetch byte address
- instr_ack  out  1  one-cycle completion pulse
- instr_rdata  out  32  fetched word; valid while instr_ack=1, held after
- data_req  in  1  data request; held with data_we/addr/wdata/be until data_ack
- data_we  in  1  1=write, 0=read
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_be  in  4  byte enables
- data_ack  out  1  one-cycle completion pulse
- data_rdata  out  32  read word; valid while data_ack=1, held after
- avm_address  out  32  to slave; bits[1:0] forced 0
- avm_read  out  1  to slave
- avm_write  out  1  to slave
- avm_writedata  out  32  to slave
- avm_byteenable  out  4  to slave; 4'b1111 for fetches
- avm_readdata  in  32  from slave; valid one cycle after accepting edge
- avm_waitrequest  in  1  from slave stall
- bus_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0; rdata registers 0; counters 0; bus_error 0.
  - An in-flight slave transaction is abandoned; no ack is issued for it.
- States: IDLE, ISSUE, WAIT_RD, DONE. All outputs are registered/Moore.
- IDLE:
  - Samples requests each edge; grant chosen at the edge.
  - Only data_req: data. Only instr_req: instr.
  - Both: data, unless starve_cnt==STARVE_LIMIT, then instr.
  - On grant: load avm_* from the granted port, assert avm_read or avm_write, go to ISSUE.
- ISSUE:
  - avm_* held stable.
  - Edge with waitrequest=0 accepts the transaction: drop avm_read/avm_write.
  - Read goes to WAIT_RD; write goes to DONE.
  - waitrequest=1 increments wait_cnt.
  - Timeout when wait_cnt reaches TIMEOUT_CYCLES with waitrequest still 1: drop strobes, set bus_error, rdata of the granted port <= 0, go to DONE.
- WAIT_RD: capture avm_readdata into the granted port's rdata register at the edge; go to DONE.
- DONE:
  - Granted port's ack=1 for exactly this cycle; requests are not sampled.
  - Next edge goes to IDLE; the requester must have dropped req by then, or a new transaction starts.
- Latency, in edges from the first IDLE edge seeing req, to ack high, with waitrequest=0:
  - Read: 3 edges (ISSUE, WAIT_RD, DONE).
  - Write: 2 edges.
  - Each waitrequest=1 cycle adds 1.
- Throughput: back-to-back reads every 4 cycles; back-to-back writes every 3 cycles.
- starve_cnt (3-bit sat):
  - +1 on a data grant while instr_req=1.
  - Cleared on an instr grant.
  - Unchanged on a data grant with instr_req=0.
- wait_cnt (8-bit): cleared on entry to ISSUE.
- avm_read and avm_write are never both 1. Exactly one ack per accepted grant. instr_ack and data_ack are never simultaneous.
- bus_error is cleared only by reset.
- Requests arriving while not in IDLE wait; they are not lost, since req is held.

Test Plan:
- Single fetch, instr_addr=0xBFC00000, slave returns 0x3C08ABCD with no stall -> avm_read high 1 cycle, avm_address=0xBFC00000, be=4'hF, instr_ack on the 3rd edge, instr_rdata=0x3C08ABCD.
- Data write addr=0xBFC00013, wdata=0x12345678, be=4'b0011, waitrequest high 2 cycles -> avm_address=0xBFC00010, avm_write held 3 cycles, data_ack on the 4th edge, no avm_read.
- Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; never both acks in one cycle.
- waitrequest stuck high, TIMEOUT_CYCLES=8, data read -> strobes drop after 8 stall cycles, bus_error=1, data_ack pulses with data_rdata=0; bus_error stays 1 afterwards.
- reset_n pulled low mid-ISSUE of a fetch -> outputs 0 immediately; after release, no instr_ack; a re-presented fetch completes normally with bus_error=0.

Source files
------------

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter
//   Shares one Avalon-MM slave between the CPU fetch port and data port.
//   One transaction at a time; data wins over fetch unless the fetch port has
//   been passed over STARVE_LIMIT times in a row. All outputs are registered.
//
// Ports
//   clk, reset_n                       clock (rising) / async active-low reset
//   instr_req/addr -> instr_ack/rdata  fetch port (read only, full-word)
//   data_req/we/addr/wdata/be
//                  -> data_ack/rdata   data port (read or write)
//   avm_*                              Avalon-MM master towards the slave
//   bus_error                          sticky: a transaction hit the stall timeout
module avalon_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        bus_error
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);
  localparam logic [7:0] TO_LIM     = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;

  state_e      state_q, state_d;
  logic        gnt_data_q, gnt_data_d;   // 1: data port owns the current transaction
  logic [2:0]  starve_q, starve_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic        iack_q, iack_d, dack_q, dack_d;
  logic        berr_q, berr_d;
  logic        pick_instr;

  // Byte-lane bits of the request addresses are dropped on the bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr[1:0], data_addr[1:0]};

  assign wait_inc = wait_q + 8'd1;
  // Fetch wins only when alone, or when data has starved it long enough.
  assign pick_instr = instr_req && (!data_req || starve_q == STARVE_LIM);

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    starve_d   = starve_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    iack_d     = 1'b0;
    dack_d     = 1'b0;
    berr_d     = berr_q;
    unique case (state_q)
      IDLE: begin
        if (instr_req || data_req) begin
          state_d = ISSUE;
          wait_d  = '0;
          if (pick_instr) begin
            gnt_data_d = 1'b0;
            addr_d     = {instr_addr[31:2], 2'b00};
            wdata_d    = '0;
            be_d       = 4'hF;
            rd_d       = 1'b1;
            wr_d       = 1'b0;
            starve_d   = '0;
          end else begin
            gnt_data_d = 1'b1;
            addr_d     = {data_addr[31:2], 2'b00};
            wdata_d    = data_wdata;
            be_d       = data_be;
            rd_d       = ~data_we;
            wr_d       = data_we;
            if (instr_req && starve_q != 3'd7) starve_d = starve_q + 3'd1;
          end
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (rd_q) begin
            state_d = WAIT_RD;
          end else begin
            state_d = DONE;
            iack_d  = ~gnt_data_q;
            dack_d  = gnt_data_q;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TO_LIM) begin
            // Abandon the stalled access; requester still gets its ack.
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            berr_d  = 1'b1;
            state_d = DONE;
            iack_d  = ~gnt_data_q;
            dack_d  = gnt_data_q;
            if (gnt_data_q) drdata_d = '0;
            else            irdata_d = '0;
          end
        end
      end
      WAIT_RD: begin
        if (gnt_data_q) drdata_d = avm_readdata;
        else            irdata_d = avm_readdata;
        state_d = DONE;
        iack_d  = ~gnt_data_q;
        dack_d  = gnt_data_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_data_q <= 1'b0;
      starve_q   <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
      iack_q     <= 1'b0;
      dack_q     <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      starve_q   <= starve_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
      iack_q     <= iack_d;
      dack_q     <= dack_d;
      berr_q     <= berr_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign instr_ack      = iack_q;
  assign instr_rdata    = irdata_q;
  assign data_ack       = dack_q;
  assign data_rdata     = drdata_q;
  assign bus_error      = berr_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb_avalon_mem_arbiter
//   Directed + randomized bench for avalon_mem_arbiter. A small word RAM with a
//   programmable waitrequest stall stands in for the slave; a reference memory
//   and expected-latency rules derived from the protocol produce all expectations.
module tb_avalon_mem_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_ack;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_be = '0;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  avalon_mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .bus_error(bus_error)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h3C08ABCD + 32'h01010101 * i;
  endfunction

  // ---- slave: 64-word RAM, stall_cfg waitrequest cycles per access ----
  logic [31:0] smem [64];
  bit          smem_init = 1'b0;
  int          stall_left = 0;
  int          stall_cfg = 0;
  assign avm_waitrequest = (avm_read || avm_write) && stall_left != 0;

  always @(posedge clk) begin
    if (!smem_init) begin
      for (int i = 0; i < 64; i++) smem[i] <= init_word(i);
      smem_init <= 1'b1;
    end
    if (avm_read || avm_write) begin
      if (stall_left != 0) stall_left <= stall_left - 1;
      else if (avm_write) begin
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) smem[avm_address[7:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
      end else avm_readdata <= smem[avm_address[7:2]];
    end else stall_left <= stall_cfg;
  end

  // ---- reference state ----
  logic [31:0] ref_mem [64];
  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;
  logic        exp_berr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from idle to ack, then one more edge back to idle.
  task automatic txn(input string nm, input bit is_data, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall);
    int edges = 0, strobe_cyc = 0, bad = 0, both = 0, oth = 0, exp_lat;
    bit got = 0;
    bit timed = (stall >= TO);
    logic [3:0]  exp_be = is_data ? be : 4'hF;
    logic [31:0] exp_addr = {addr[31:2], 2'b00};
    int idx = int'(addr[7:2]);
    exp_lat = timed ? 1 + TO : (we ? 2 : 3) + stall;
    stall_cfg = stall;
    if (is_data) begin
      data_req = 1; data_we = we; data_addr = addr; data_wdata = wdata; data_be = be;
    end else begin
      instr_req = 1; instr_addr = addr;
    end
    while (!got && edges < 400) begin
      step();
      edges++;
      if (avm_read || avm_write) begin
        strobe_cyc++;
        if (avm_address !== exp_addr || avm_byteenable !== exp_be || avm_read === we ||
            avm_write !== we || (we && avm_writedata !== wdata)) bad++;
      end
      if (avm_read && avm_write) both++;
      if (is_data ? instr_ack : data_ack) oth++;
      if (is_data ? data_ack : instr_ack) got = 1;
    end
    instr_req = 0;
    data_req  = 0;
    if (timed) begin
      exp_berr = 1'b1;
      if (is_data) exp_drd = '0; else exp_ird = '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      if (is_data) exp_drd = ref_mem[idx]; else exp_ird = ref_mem[idx];
    end
    chk({nm, ".ack_seen"}, 32'(got), 32'd1);
    chk({nm, ".latency"}, edges, exp_lat);
    chk({nm, ".strobe_cycles"}, strobe_cyc, timed ? TO : 1 + stall);
    chk({nm, ".bus_fields"}, bad, 0);
    chk({nm, ".rd_wr_both"}, both, 0);
    chk({nm, ".other_ack"}, oth, 0);
    chk({nm, ".instr_rdata"}, instr_rdata, exp_ird);
    chk({nm, ".data_rdata"}, data_rdata, exp_drd);
    chk({nm, ".bus_error"}, 32'(bus_error), 32'(exp_berr));
    step();
    chk({nm, ".ack_one_cycle"}, 32'({instr_ack, data_ack}), 32'd0);
  endtask

  initial begin
    string seq, exp_seq;
    int cnt, edges, both_ack, quiet_acks;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // reset state
    step(); step();
    chk("rst.avm_read", 32'(avm_read), 32'd0);
    chk("rst.avm_write", 32'(avm_write), 32'd0);
    chk("rst.avm_address", avm_address, 32'd0);
    chk("rst.acks", 32'({instr_ack, data_ack}), 32'd0);
    chk("rst.rdata", instr_rdata | data_rdata, 32'd0);
    chk("rst.bus_error", 32'(bus_error), 32'd0);
    reset_n = 1'b1;
    step();

    // directed fetch and stalled partial write
    txn("fetch", 0, 0, 32'hBFC00000, 32'h0, 4'h0, 0);
    chk("fetch.word", instr_rdata, 32'h3C08ABCD);
    txn("wr_stall", 1, 1, 32'hBFC00013, 32'h12345678, 4'b0011, 2);
    txn("rd_back", 1, 0, 32'hBFC00010, 32'h0, 4'hF, 0);

    // randomized single-port traffic
    for (int k = 0; k < 40; k++) begin
      bit d = 1'($urandom_range(0, 1));
      txn($sformatf("rnd%0d", k), d, d ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, $urandom,
          4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // both requesters held: starvation guard ordering
    exp_seq = ""; cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == SL) begin exp_seq = {exp_seq, "I"}; cnt = 0; end
      else begin exp_seq = {exp_seq, "D"}; cnt++; end
    end
    stall_cfg = 0;
    instr_addr = 32'h0000_0020; data_addr = 32'h0000_0084; data_we = 0; data_be = 4'hF;
    instr_req = 1; data_req = 1;
    seq = ""; edges = 0; both_ack = 0;
    while (seq.len() < 10 && edges < 200) begin
      step(); edges++;
      if (instr_ack && data_ack) both_ack++;
      if (data_ack) seq = {seq, "D"};
      if (instr_ack) seq = {seq, "I"};
    end
    instr_req = 0; data_req = 0;
    step();
    n_tests++;
    assert (seq == exp_seq) else begin
      n_fail++;
      $error("FAIL starve.order: observed %s expected %s", seq, exp_seq);
    end
    chk("starve.both_ack", both_ack, 0);
    exp_ird = ref_mem[8];
    exp_drd = ref_mem[33];
    chk("starve.instr_rdata", instr_rdata, exp_ird);
    chk("starve.data_rdata", data_rdata, exp_drd);

    // stuck waitrequest -> timeout, sticky error
    txn("timeout", 1, 0, 32'h0000_0040, 32'h0, 4'hF, 255);
    txn("after_to", 0, 0, 32'h0000_0044, 32'h0, 4'h0, 1);

    // reset in the middle of a stalled fetch
    stall_cfg = 5;
    instr_addr = 32'h0000_0048; instr_req = 1;
    step(); step();
    chk("midrst.issuing", 32'(avm_read), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst.avm_read", 32'(avm_read), 32'd0);
    chk("midrst.avm_address", avm_address, 32'd0);
    chk("midrst.bus_error", 32'(bus_error), 32'd0);
    chk("midrst.rdata", instr_rdata | data_rdata, 32'd0);
    exp_ird = '0; exp_drd = '0; exp_berr = 1'b0;
    instr_req = 0;
    step();
    reset_n = 1'b1;
    quiet_acks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (instr_ack || data_ack) quiet_acks++;
    end
    chk("midrst.no_ack", quiet_acks, 0);
    txn("refetch", 0, 0, 32'h0000_0048, 32'h0, 4'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
